// File: rtl/ttt_pkg.sv
// Shared types and cell-index helpers for the tic-tac-toe move driver.
// Cells hold 3 when empty, otherwise the id (0/1) of the player who took them.
package ttt_pkg;

    typedef logic [1:0] cell_t;

    localparam cell_t CELL_EMPTY  = 2'd3;
    localparam cell_t PLAYER_NONE = 2'd3;

    // Indexed board[y][x]
    typedef logic [2:0][2:0][1:0] board_t;

    typedef enum logic [2:0] {IDLE, WAIT_H, SCAN, ISSUE, DONE} state_t;

    function automatic logic [1:0] idx2x(input logic [3:0] idx);
        return 2'(idx % 4'd3);
    endfunction

    function automatic logic [1:0] idx2y(input logic [3:0] idx);
        return 2'(idx / 4'd3);
    endfunction

    function automatic logic [3:0] idx_next(input logic [3:0] idx);
        return (idx >= 4'd8) ? 4'd0 : idx + 4'd1;
    endfunction

endpackage

// File: rtl/ttt_cell_scanner.sv
// Walks the board one cell per cycle looking for an empty cell for the CPU move.
// The index wraps 8 -> 0 and is reloaded with SCAN_START on every restart pulse.
module ttt_cell_scanner
    import ttt_pkg::*;
#(
    parameter int SCAN_START = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic       advance,
    input  board_t     board,
    output logic       found,
    output logic [3:0] idx
);

    logic [3:0] idx_q;
    logic [3:0] idx_d;

    assign found = (board[idx2y(idx_q)][idx2x(idx_q)] == CELL_EMPTY);
    assign idx   = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (restart) begin
            idx_d = 4'(SCAN_START);
        end else if (advance && !found) begin
            idx_d = idx_next(idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= 4'(SCAN_START);
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/ttt_move_driver.sv
// Issues legal, strictly alternating moves to the game engine from a human
// handshake and a CPU board scan, tracking its own shadow copy of the board.
module ttt_move_driver
    import ttt_pkg::*;
#(
    parameter int HUMAN_PLAYER = 0,
    parameter int FIRST_PLAYER = 0,
    parameter int SCAN_START   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop_game,
    input  logic       move_valid,
    input  logic [1:0] move_x,
    input  logic [1:0] move_y,
    output logic       move_ready,
    output logic       move_err,
    output logic       enable,
    output logic [1:0] data_out_x,
    output logic [1:0] data_out_y,
    output logic [1:0] player_out,
    output logic       busy,
    output logic       board_full,
    output logic [3:0] move_count
);

    localparam logic HUMAN = 1'(HUMAN_PLAYER);
    localparam logic FIRST = 1'(FIRST_PLAYER);
    localparam state_t START_STATE = (FIRST == HUMAN) ? WAIT_H : SCAN;

    state_t     state_q, state_d;
    board_t     board_q, board_d;
    logic [3:0] count_q, count_d;
    logic       turn_q, turn_d;
    logic [1:0] mv_x_q, mv_x_d, mv_y_q, mv_y_d;
    logic [1:0] out_x_q, out_x_d, out_y_q, out_y_d;
    cell_t      player_q, player_d;
    logic       err_q, err_d;

    logic       in_range, legal;
    logic [1:0] hx, hy;
    logic       scan_found, scan_restart;
    logic [3:0] scan_idx;

    // Clamp the index so an out-of-range offer never reads outside the board
    assign in_range = (move_x < 2'd3) && (move_y < 2'd3);
    assign hx       = in_range ? move_x : 2'd0;
    assign hy       = in_range ? move_y : 2'd0;
    assign legal    = in_range && (board_q[hy][hx] == CELL_EMPTY);

    assign scan_restart = (state_d == SCAN) && (state_q != SCAN);

    ttt_cell_scanner #(.SCAN_START(SCAN_START)) u_scanner (
        .clk     (clk),
        .reset   (reset),
        .restart (scan_restart),
        .advance (state_q == SCAN),
        .board   (board_q),
        .found   (scan_found),
        .idx     (scan_idx)
    );

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        count_d  = count_q;
        turn_d   = turn_q;
        mv_x_d   = mv_x_q;
        mv_y_d   = mv_y_q;
        out_x_d  = out_x_q;
        out_y_d  = out_y_q;
        player_d = player_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    board_d = {9{CELL_EMPTY}};
                    count_d = 4'd0;
                    turn_d  = FIRST;
                    state_d = START_STATE;
                end
            end
            WAIT_H: begin
                if (stop_game) begin
                    state_d = DONE;
                end else if (move_valid) begin
                    if (legal) begin
                        mv_x_d  = move_x;
                        mv_y_d  = move_y;
                        state_d = ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (stop_game) begin
                    state_d = DONE;
                end else if (scan_found) begin
                    mv_x_d  = idx2x(scan_idx);
                    mv_y_d  = idx2y(scan_idx);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (stop_game) begin
                    state_d = DONE;
                end else begin
                    board_d[mv_y_q][mv_x_q] = {1'b0, turn_q};
                    count_d  = count_q + 4'd1;
                    turn_d   = ~turn_q;
                    out_x_d  = mv_x_q;
                    out_y_d  = mv_y_q;
                    player_d = {1'b0, turn_q};
                    if (count_q == 4'd8) begin
                        state_d = DONE;
                    end else begin
                        state_d = (~turn_q == HUMAN) ? WAIT_H : SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            board_q  <= {9{CELL_EMPTY}};
            count_q  <= 4'd0;
            turn_q   <= FIRST;
            mv_x_q   <= 2'd0;
            mv_y_q   <= 2'd0;
            out_x_q  <= 2'd0;
            out_y_q  <= 2'd0;
            player_q <= PLAYER_NONE;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            count_q  <= count_d;
            turn_q   <= turn_d;
            mv_x_q   <= mv_x_d;
            mv_y_q   <= mv_y_d;
            out_x_q  <= out_x_d;
            out_y_q  <= out_y_d;
            player_q <= player_d;
            err_q    <= err_d;
        end
    end

    // A stop arriving during ISSUE suppresses the pulse in the same cycle
    assign enable     = (state_q == ISSUE) && !stop_game;
    assign data_out_x = enable ? mv_x_q : out_x_q;
    assign data_out_y = enable ? mv_y_q : out_y_q;
    assign player_out = enable ? {1'b0, turn_q} : player_q;
    assign move_ready = (state_q == WAIT_H);
    assign move_err   = err_q;
    assign busy       = (state_q == WAIT_H) || (state_q == SCAN) || (state_q == ISSUE);
    assign board_full = (state_q == DONE) && (count_q == 4'd9);
    assign move_count = count_q;

endmodule

// File: tb/tb_ttt_move_driver.sv
// Scoreboard bench for ttt_move_driver: a small board model predicts every issued move.
module tb_ttt_move_driver;

    localparam int SCAN_START = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop_game = 1'b0;
    logic       move_valid = 1'b0;
    logic [1:0] move_x = 2'd0;
    logic [1:0] move_y = 2'd0;
    logic       move_ready, move_err, enable, busy, board_full;
    logic [1:0] data_out_x, data_out_y, player_out;
    logic [3:0] move_count;

    logic       start8 = 1'b0;
    logic       valid8 = 1'b0;
    logic [1:0] x8 = 2'd0;
    logic [1:0] y8 = 2'd0;
    logic       ready8, err8, en8, busy8, full8;
    logic [1:0] ox8, oy8, p8;
    logic [3:0] cnt8;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [5:0] sb_q[$];
    logic [5:0] sb_e;
    int         mb[9];
    int         mcnt;
    int         order[9] = '{0, 1, 3, 6, 7, 2, 5, 8, 4};
    int         guard;
    int         wait_n;

    always #5 clk = ~clk;

    ttt_move_driver #(.HUMAN_PLAYER(0), .FIRST_PLAYER(0), .SCAN_START(SCAN_START)) dut (
        .clk(clk), .reset(reset), .start(start), .stop_game(stop_game),
        .move_valid(move_valid), .move_x(move_x), .move_y(move_y),
        .move_ready(move_ready), .move_err(move_err), .enable(enable),
        .data_out_x(data_out_x), .data_out_y(data_out_y), .player_out(player_out),
        .busy(busy), .board_full(board_full), .move_count(move_count)
    );

    ttt_move_driver #(.HUMAN_PLAYER(0), .FIRST_PLAYER(0), .SCAN_START(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .stop_game(1'b0),
        .move_valid(valid8), .move_x(x8), .move_y(y8),
        .move_ready(ready8), .move_err(err8), .enable(en8),
        .data_out_x(ox8), .data_out_y(oy8), .player_out(p8),
        .busy(busy8), .board_full(full8), .move_count(cnt8)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 9; i++) mb[i] = 3;
        mcnt = 0;
    endtask

    function automatic int cpu_pick();
        int i = SCAN_START;
        for (int n = 0; n < 9; n++) begin
            if (mb[i] == 3) return i;
            i = (i == 8) ? 0 : i + 1;
        end
        return 0;
    endfunction

    // Offers one human move; returns one cycle after the accepting edge
    task automatic human_move(input int x, input int y, input bit push);
        int n = 0;
        int idx;
        int c;
        while (move_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (n == 40) check("ready_timeout", 0, 1);
        move_valid = 1'b1;
        move_x = 2'(x);
        move_y = 2'(y);
        idx = y * 3 + x;
        if (push && x < 3 && y < 3 && mb[idx] == 3) begin
            sb_q.push_back({2'(x), 2'(y), 2'd0});
            mb[idx] = 0;
            mcnt++;
            if (mcnt < 9) begin
                c = cpu_pick();
                sb_q.push_back({2'(c % 3), 2'(c / 3), 2'd1});
                mb[c] = 1;
                mcnt++;
            end
        end
        tick();
        move_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (enable === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_enable", 1, 0);
            end else begin
                sb_e = sb_q.pop_front();
                check("sb_move_xyp", {26'd0, data_out_x, data_out_y, player_out}, {26'd0, sb_e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        model_clear();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_player_out", player_out, 3);
        check("rst_enable", enable, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", move_ready, 0);
        check("rst_count", move_count, 0);
        check("rst_data_x", data_out_x, 0);
        check("rst_full", board_full, 0);
        check("rst_err", move_err, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ready", move_ready, 1);
        check("start_busy", busy, 1);

        human_move(1, 1, 1);
        check("h_enable", enable, 1);
        check("h_x", data_out_x, 1);
        check("h_y", data_out_y, 1);
        check("h_player", player_out, 0);
        tick();
        check("scan_ready", move_ready, 0);
        check("scan_enable", enable, 0);
        check("scan_hold_player", player_out, 0);
        tick();
        check("scan_enable2", enable, 0);
        tick();
        check("cpu_enable", enable, 1);
        check("cpu_x", data_out_x, 2);
        check("cpu_y", data_out_y, 1);
        check("cpu_player", player_out, 1);
        tick();
        check("after_cpu_ready", move_ready, 1);
        check("after_cpu_count", move_count, 2);

        human_move(1, 1, 1);
        check("err_occupied", move_err, 1);
        check("err_occ_enable", enable, 0);
        check("err_occ_ready", move_ready, 1);
        human_move(3, 0, 1);
        check("err_range", move_err, 1);
        check("err_range_ready", move_ready, 1);
        tick();
        check("err_clear", move_err, 0);
        check("err_count", move_count, 2);

        guard = 0;
        while (mcnt < 9 && guard < 12) begin
            for (int i = 0; i < 9; i++) begin
                if (mb[order[i]] == 3) begin
                    human_move(order[i] % 3, order[i] / 3, 1);
                    break;
                end
            end
            guard++;
        end
        wait_n = 0;
        while (busy !== 1'b0 && wait_n < 20) begin
            tick();
            wait_n++;
        end
        check("full_flag", board_full, 1);
        check("full_count", move_count, 9);
        check("full_busy", busy, 0);
        check("full_ready", move_ready, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
        check("restart_full", board_full, 0);
        check("restart_count", move_count, 0);
        check("restart_ready", move_ready, 1);

        human_move(0, 0, 0);
        stop_game = 1'b1;
        #1;
        check("stop_issue_enable", enable, 0);
        tick();
        stop_game = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_cell", dut.board_q[0][0], 3);
        check("stop_count", move_count, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        stop_game = 1'b1;
        move_valid = 1'b1;
        move_x = 2'd3;
        move_y = 2'd3;
        tick();
        move_valid = 1'b0;
        stop_game = 1'b0;
        check("stop_drop_err", move_err, 0);
        check("stop_drop_busy", busy, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        human_move(1, 1, 1);
        tick();
        check("rs_in_scan", move_ready, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        sb_q.delete();
        model_clear();
        check("rs_board", dut.board_q, 32'h3FFFF);
        check("rs_player", player_out, 3);
        check("rs_enable", enable, 0);
        check("rs_busy", busy, 0);

        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("w_ready", ready8, 1);
        valid8 = 1'b1;
        x8 = 2'd2;
        y8 = 2'd2;
        tick();
        valid8 = 1'b0;
        check("w_h_enable", en8, 1);
        check("w_h_xy", {ox8, oy8}, 4'b1010);
        tick();
        check("w_scan8", en8, 0);
        tick();
        check("w_scan0", en8, 0);
        tick();
        check("w_cpu_enable", en8, 1);
        check("w_cpu_x", ox8, 0);
        check("w_cpu_y", oy8, 0);
        check("w_cpu_player", p8, 1);
        tick();
        check("w_count", cnt8, 2);
        check("w_busy", busy8, 1);
        check("w_err", err8, 0);
        check("w_full", full8, 0);

        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
